// File: rtl/soc_pio_pkg.sv
// Register word addresses and edge-capture mode encodings for the soc PIO block.
package soc_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_OUTRB  = 3'd1;
    localparam logic [2:0] ADDR_IRQMSK = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/soc_pio_sync_edge.sv
// Input synchroniser, one-cycle history and edge detector for the PIO input port.
// Detection stays gated until the pipeline has been refilled after reset.
module soc_pio_sync_edge
    import soc_pio_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] sync_q,
    output logic [DATA_W-1:0] det
);

    localparam edge_type_e MODE    = edge_type_e'(EDGE_TYPE);
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [DATA_W-1:0] chain [SYNC_STAGES];
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] raw;
    logic [2:0]        arm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev    <= '0;
            arm_cnt <= '0;
        end else begin
            chain[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= sync_q;
            if (arm_cnt != ARM_MAX) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];

    always_comb begin
        raw = '0;
        case (MODE)
            EDGE_RISE: raw = sync_q & ~prev;
            EDGE_FALL: raw = ~sync_q & prev;
            default:   raw = sync_q ^ prev;
        endcase
    end

    // Inputs held high through reset must not look like edges while the chain refills.
    assign det = (arm_cnt == ARM_MAX) ? raw : '0;

endmodule

// File: rtl/soc_pio_gen2.sv
// Parametrised Avalon-MM parallel I/O port: output register with set/clear,
// synchronised input sampling, sticky edge capture and masked level interrupt.
module soc_pio_gen2
    import soc_pio_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              irq
);

    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] irq_mask;
    logic [DATA_W-1:0] edge_cap;
    logic [DATA_W-1:0] clr_mask;
    logic [DATA_W-1:0] sync_q;
    logic [DATA_W-1:0] det;
    logic [31:0]       rd_mux;

    assign wr       = chipselect & ~write_n;
    assign rd       = chipselect & ~read_n;
    assign wd       = writedata[DATA_W-1:0];
    assign clr_mask = (wr && address == ADDR_EDGE) ? wd : '0;
    assign out_port = out_reg;

    soc_pio_sync_edge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_q  (sync_q),
        .det     (det)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux[DATA_W-1:0] = sync_q;
            ADDR_OUTRB:  rd_mux[DATA_W-1:0] = out_reg;
            ADDR_IRQMSK: rd_mux[DATA_W-1:0] = irq_mask;
            ADDR_EDGE:   rd_mux[DATA_W-1:0] = edge_cap;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg  <= RESET_VALUE;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:   out_reg  <= wd;
                    ADDR_OUTSET: out_reg  <= out_reg | wd;
                    ADDR_OUTCLR: out_reg  <= out_reg & ~wd;
                    ADDR_IRQMSK: irq_mask <= wd;
                    default: ;
                endcase
            end
            // A fresh edge overrides a same-cycle clear of that bit.
            edge_cap <= (edge_cap & ~clr_mask) | det;
            irq      <= |(edge_cap & irq_mask);
            if (rd) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule
